// File: rtl/fpu_pkg.sv
// Shared types and constants for the multi-cycle single-precision adder controller.
//   - state_e     : FSM state encoding
//   - fp_fields_t : unpacked view of an IEEE-754 single (sign, exponent, hidden-bit mantissa, zero flag)
//   - abs_diff    : absolute difference of two biased exponents
package fpu_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned EXP_W       = 8;
    localparam int unsigned FRAC_W      = 23;
    localparam int unsigned MANT_W      = 25;
    localparam int unsigned EXP_MAX     = 255;
    localparam int unsigned ALIGN_LIMIT = 25;

    // Internal exponent carries two spare bits so a carry past 255 stays visible.
    localparam int unsigned EXP_IW      = EXP_W + 2;
    // Alignment counter only ever holds values below ALIGN_LIMIT.
    localparam int unsigned CNT_W       = $clog2(ALIGN_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              zero;
    } fp_fields_t;

    function automatic logic [EXP_W-1:0] abs_diff(input logic [EXP_W-1:0] a,
                                                  input logic [EXP_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/fpu_unpack.sv
// Combinational field splitter for one IEEE-754 single-precision word.
// Ports:
//   word_i   : packed 32-bit operand
//   fields_o : sign, biased exponent, 25-bit mantissa {0,1,frac} and zero flag.
// An exponent field of zero is treated as exact zero: no hidden bit, mantissa cleared.
module fpu_unpack
    import fpu_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output fp_fields_t        fields_o
);

    logic exp_zero;

    assign exp_zero = (word_i[WORD_W-2 -: EXP_W] == '0);

    always_comb begin
        fields_o.sign = word_i[WORD_W-1];
        fields_o.exp  = word_i[WORD_W-2 -: EXP_W];
        fields_o.zero = exp_zero;
        fields_o.mant = exp_zero ? '0 : {1'b0, 1'b1, word_i[FRAC_W-1:0]};
    end

endmodule

// File: rtl/fpu_add_ctrl.sv
// Multi-cycle single-precision adder controller: IDLE -> ALIGN -> ADD -> NORM -> DONE.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, sub        : request pulse and subtract select, sampled only in IDLE
//   op_a, op_b        : IEEE-754 single operands
//   busy              : high in every state except IDLE
//   done              : one-cycle pulse, result/overflow valid
//   result, overflow  : packed result (truncated) and exponent saturation flag, held until next done
// Configuration macro FPU_SIGN_EN: when defined, operand signs and sub select the
// effective operation, the result takes the sign of the larger operand, and
// left normalization is enabled. When undefined the block is a pure magnitude adder.
module fpu_add_ctrl
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    input  logic              sub,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              overflow
);

    fp_fields_t fa;
    fp_fields_t fb;

    state_e              state_q, state_d;
    logic [MANT_W-1:0]   max_q, max_d;
    logic [MANT_W-1:0]   min_q, min_d;
    logic [MANT_W-1:0]   sum_q, sum_d;
    logic [EXP_IW-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic                eff_sub_q, eff_sub_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WORD_W-1:0]   result_q, result_d;
    logic                overflow_q, overflow_d;

    logic                a_larger_c;
    logic [EXP_W-1:0]    exp_diff_c;
    logic                far_c;
    logic                unused_c;

    fpu_unpack u_unpack_a (
        .word_i   (op_a),
        .fields_o (fa)
    );

    fpu_unpack u_unpack_b (
        .word_i   (op_b),
        .fields_o (fb)
    );

    // Magnitude ordering: exponent first, mantissa breaks ties; A wins on equality.
    assign a_larger_c = (fa.exp > fb.exp) ||
                        ((fa.exp == fb.exp) && (fa.mant >= fb.mant));
    assign exp_diff_c = abs_diff(fa.exp, fb.exp);
    // Beyond ALIGN_LIMIT the smaller operand would be shifted out entirely.
    assign far_c      = (exp_diff_c >= EXP_W'(ALIGN_LIMIT));

`ifdef FPU_SIGN_EN
    assign unused_c = ^{fa.zero, fb.zero};
`else
    assign unused_c = ^{fa.zero, fb.zero, fa.sign, fb.sign, sub};
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            max_q      <= '0;
            min_q      <= '0;
            sum_q      <= '0;
            exp_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            eff_sub_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            min_q      <= min_d;
            sum_q      <= sum_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            eff_sub_q  <= eff_sub_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        max_d      = max_q;
        min_d      = min_q;
        sum_d      = sum_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        eff_sub_d  = eff_sub_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    max_d   = a_larger_c ? fa.mant : fb.mant;
                    min_d   = far_c ? '0 : (a_larger_c ? fb.mant : fa.mant);
                    cnt_d   = far_c ? '0 : CNT_W'(exp_diff_c);
                    exp_d   = EXP_IW'(a_larger_c ? fa.exp : fb.exp);
`ifdef FPU_SIGN_EN
                    eff_sub_d = fa.sign ^ fb.sign ^ sub;
                    sign_d    = a_larger_c ? fa.sign : (fb.sign ^ sub);
`else
                    eff_sub_d = 1'b0;
                    sign_d    = 1'b0;
`endif
                    state_d = S_ALIGN;
                end
            end

            S_ALIGN: begin
                if (cnt_q != '0) begin
                    min_d = min_q >> 1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                // max >= min by construction, so subtraction never wraps.
                sum_d   = eff_sub_q ? (max_q - min_q) : (max_q + min_q);
                state_d = S_NORM;
            end

            S_NORM: begin
                if (sum_q == '0) begin
                    // Exact cancellation always yields +0.
                    exp_d      = '0;
                    result_d   = '0;
                    overflow_d = 1'b0;
                    state_d    = S_DONE;
                end else if (sum_q[MANT_W-1]) begin
                    sum_d = sum_q >> 1;
                    exp_d = exp_q + EXP_IW'(1);
                end
`ifdef FPU_SIGN_EN
                else if (!sum_q[FRAC_W]) begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - EXP_IW'(1);
                end
`endif
                else begin
                    state_d = S_DONE;
                    if (exp_q >= EXP_IW'(EXP_MAX)) begin
                        overflow_d = 1'b1;
                        result_d   = {sign_q, EXP_W'(EXP_MAX), FRAC_W'(0)};
                    end else begin
                        overflow_d = 1'b0;
                        result_d   = {sign_q, exp_q[EXP_W-1:0], sum_q[FRAC_W-1:0]};
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags registered alongside the state they describe.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: doc/fpu_add_ctrl.md
FPU_ADD_CTRL -- requirements
Module: fpu_add_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  request pulse; sampled only in IDLE.
REQ-004 SHALL have port: op_a  in  32  IEEE-754 single operand A.
REQ-005 SHALL have port: op_b  in  32  IEEE-754 single operand B.
REQ-006 SHALL have port: sub  in  1  1 = compute A-B; sampled with start.
REQ-007 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port: done  out  1  one-cycle pulse; result valid.
REQ-009 SHALL have port: result  out  32  packed sum, held until next done.
REQ-010 SHALL have port: overflow  out  1  exponent saturated; updated with done.

Function
REQ-011 SHALL implement FSM IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE.
REQ-012 IDLE, start=1: latch operands, exponent field 0 = exact zero (no hidden bit), else mantissa {1,frac} in 25-bit reg; larger-magnitude operand (exp, then mantissa) to max, other to min; cnt = |ea-eb|.
REQ-013 IDLE, if |ea-eb| >= 25: min mantissa cleared, cnt = 0.
REQ-014 ALIGN: cnt != 0 -> min >>= 1, cnt -= 1, stay; cnt == 0 -> ADD.
REQ-015 ADD: sum = max + min (effective add) or max - min (effective subtract); -> NORM.
REQ-016 NORM, per cycle priority: sum == 0 -> exp = 0 then DONE; sum[24] -> sum >>= 1, exp += 1, stay; sum[23] == 0 -> sum <<= 1, exp -= 1, stay; else DONE.
REQ-017 Rounding SHALL be truncation; shifted-out bits discarded.
REQ-018 Exponent reaching 255 SHALL force result {sign, 8'hFF, 23'b0}, overflow = 1.
REQ-019 DONE: done = 1 for exactly one cycle, result = {sign, exp[7:0], sum[22:0]}; -> IDLE.
REQ-020 Latency: done asserted in cycle 4 + a + n after start cycle 0; a = |ea-eb| if < 25 else 0; n = normalization shifts.
REQ-021 start while busy SHALL be ignored, no queueing; back-to-back start accepted the cycle after DONE.
REQ-022 Zero result SHALL be +0 (0x00000000).

Reset
REQ-023 reset SHALL force IDLE, busy = 0, done = 0, result = 0, overflow = 0, cnt = 0.
REQ-024 reset mid-operation SHALL abort without a done pulse; reset priority over start.

Configuration
REQ-025 Macro FPU_SIGN_EN defined: effective op = sign_a ^ sign_b ^ sub; result sign = sign of larger-magnitude operand (B's sign xor sub when B larger); left normalization active.
REQ-026 FPU_SIGN_EN undefined: sign bits and sub ignored, always magnitude add, result sign 0, left-shift branch absent; port list unchanged.

Structure
REQ-027 Shared package fpu_pkg SHALL hold FSM state enum, EXP_W = 8, FRAC_W = 23, MANT_W = 25, EXP_MAX = 255, ALIGN_LIMIT = 25.
REQ-028 One combinational sub-module fpu_unpack SHALL split a 32-bit word into sign, exponent, hidden-bit mantissa and zero flag; instantiated twice.

Verification
REQ-029 0x3F800000 + 0x3F800000 -> result 0x40000000, overflow 0, done in cycle 5, busy cycles 1-5.
REQ-030 0x3F800000 + 0x3F000000 -> 0x3FC00000, done in cycle 5.
REQ-031 0x4E800000 + 0x3F800000 (diff 30) -> 0x4E800000, done in cycle 4.
REQ-032 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow 1, done in cycle 5.
REQ-033 FPU_SIGN_EN: 0x3F800000 - 0x3F400000 -> 0x3E800000, done in cycle 7; 0x40400000 - 0x40400000 -> 0x00000000, done in cycle 4.
REQ-034 reset asserted in ALIGN, then start during busy -> no done, outputs zero; start mid-op ignored, result unchanged.
